// File: rtl/wb_stage_pkg.sv
// Shared types and helpers for the writeback stage: load-op codes, FSM states,
// register-file constants and the misalignment rule.
package wb_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LOAD_OP_W  = 3;

  localparam logic [REG_W-1:0] ZERO_WORD    = '0;
  localparam logic             RST_ENABLE   = 1'b0;
  localparam logic             WRITE_ENABLE = 1'b1;

  typedef enum logic [LOAD_OP_W-1:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4
  } load_op_e;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_DRAIN = 2'd2
  } wb_state_e;

  // Any code that is not a byte or halfword access behaves as a word access.
  function automatic logic load_misaligned(input logic [LOAD_OP_W-1:0] op,
                                           input logic [1:0]           lo);
    logic mis;
    case (op)
      LB, LBU: mis = 1'b0;
      LH, LHU: mis = lo[0];
      default: mis = (lo != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Byte/halfword lane selection and sign/zero extension of a data-memory read word.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_W
) (
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr_lo,
  input  logic [DATA_W-1:0]    rdata,
  output logic [DATA_W-1:0]    aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    aligned = rdata;
    case (load_op)
      LB:      aligned = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LBU:     aligned = {{(DATA_W-8){1'b0}}, byte_sel};
      LH:      aligned = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LHU:     aligned = {{(DATA_W-16){1'b0}}, half_sel};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: forwards ALU results, waits for and aligns load data, and
// drives a registered one-cycle register-file write pulse.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 wb_ready,
  input  logic                 mem_wreg,
  input  logic [ADDR_W-1:0]    mem_waddr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_is_load,
  input  logic [LOAD_OP_W-1:0] mem_load_op,
  input  logic [1:0]           mem_addr_lo,
  input  logic                 dmem_rvalid,
  input  logic [DATA_W-1:0]    dmem_rdata,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 wb_we,
  output logic [ADDR_W-1:0]    wb_waddr,
  output logic [DATA_W-1:0]    wb_wdata,
  output logic                 wb_pend,
  output logic [ADDR_W-1:0]    wb_pend_waddr,
  output logic                 wb_misalign
);

  wb_state_e state_q, state_d;

  logic                 wreg_q;
  logic [ADDR_W-1:0]    waddr_q;
  logic [LOAD_OP_W-1:0] op_q;
  logic [1:0]           lo_q;

  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0]    wb_wdata_q, wb_wdata_d;
  logic                 mis_q, mis_d;

  logic                 accept, ld_accept, ld_mis, capture;
  logic [DATA_W-1:0]    aligned;

  load_align #(.DATA_W(DATA_W)) u_align (
    .load_op (op_q),
    .addr_lo (lo_q),
    .rdata   (dmem_rdata),
    .aligned (aligned)
  );

  assign accept    = mem_valid && wb_ready;
  assign ld_accept = accept && mem_is_load;
  assign ld_mis    = load_misaligned(mem_load_op, mem_addr_lo);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state_q <= WB_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE:  if (ld_accept && !ld_mis) state_d = WB_WAIT;
      WB_WAIT: begin
        if (flush)            state_d = dmem_rvalid ? WB_IDLE : WB_DRAIN;
        else if (dmem_rvalid) state_d = WB_IDLE;
      end
      WB_DRAIN: if (dmem_rvalid) state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    wb_ready   = (state_q == WB_IDLE) && !stall && !flush;
    wb_pend    = (state_q == WB_WAIT) && wreg_q && (waddr_q != '0);
    we_d       = 1'b0;
    mis_d      = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    capture    = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (accept && !mem_is_load) begin
          we_d       = mem_wreg && (mem_waddr != '0);
          wb_waddr_d = mem_waddr;
          wb_wdata_d = mem_wdata;
        end
        capture = ld_accept;
        mis_d   = ld_accept && ld_mis;
      end
      WB_WAIT: begin
        // A flush kills the write even when the response lands this cycle.
        if (dmem_rvalid && !flush) begin
          we_d       = wreg_q && (waddr_q != '0);
          wb_waddr_d = waddr_q;
          wb_wdata_d = aligned;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      we_q       <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= ZERO_WORD;
      mis_q      <= 1'b0;
      wreg_q     <= 1'b0;
      waddr_q    <= '0;
      op_q       <= '0;
      lo_q       <= '0;
    end else begin
      we_q       <= we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      mis_q      <= mis_d;
      if (capture) begin
        wreg_q  <= mem_wreg;
        waddr_q <= mem_waddr;
        op_q    <= mem_load_op;
        lo_q    <= mem_addr_lo;
      end
    end
  end

  assign wb_we         = we_q;
  assign wb_waddr      = wb_waddr_q;
  assign wb_wdata      = wb_wdata_q;
  assign wb_misalign   = mis_q;
  assign wb_pend_waddr = waddr_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage between the data-memory interface and the register file write port. Accepts one retiring instruction per handshake from the MEM stage. For ALU results it forwards the result directly. For loads it waits for the data-memory response, then extracts and extends the addressed byte or halfword. It drives a registered single-cycle write pulse (`we`/`waddr`/`wdata`) into the register file and exposes pending-load status for decode hazard detection.

## Interface
- `DATA_W`, 32, register/data width (`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — asynchronous, active-low reset (asserted when 0)
- `mem_valid` in 1 — MEM stage presents an instruction
- `wb_ready` out 1 — stage can accept this cycle
- `mem_wreg` in 1 — instruction writes a register
- `mem_waddr` in 5 — destination register
- `mem_wdata` in 32 — ALU result (ignored for loads)
- `mem_is_load` in 1 — instruction is a load
- `mem_load_op` in 3 — LB/LBU/LH/LHU/LW code
- `mem_addr_lo` in 2 — byte offset of load address
- `dmem_rvalid` in 1 — data-memory read response valid
- `dmem_rdata` in 32 — data-memory read word
- `stall` in 1 — ctrl stall, blocks acceptance
- `flush` in 1 — ctrl flush, cancels pending load
- `wb_we` out 1 — regfile write enable pulse
- `wb_waddr` out 5 — regfile write address
- `wb_wdata` out 32 — regfile write data
- `wb_pend` out 1 — load in flight with a non-zero destination
- `wb_pend_waddr` out 5 — destination of in-flight load
- `wb_misalign` out 1 — one-cycle misaligned-load pulse

## Operation
- States: IDLE, WAIT, DRAIN.
- `wb_ready` = (state==IDLE) && !stall && !flush. An instruction is accepted when `mem_valid` && `wb_ready`.
- **IDLE, non-load accept:**
  - Next cycle `wb_we` = `mem_wreg` && (`mem_waddr` != 0).
  - `wb_waddr` = `mem_waddr`, `wb_wdata` = `mem_wdata`.
  - State stays IDLE.
- **IDLE, load accept:**
  - Capture `waddr`, `wreg`, `load_op`, `addr_lo`, then go to WAIT.
  - Misaligned loads are LH/LHU with `addr_lo[0]`=1, or LW with `addr_lo`!=0. These do not enter WAIT and issue no memory wait. Next cycle: `wb_misalign`=1, `wb_we`=0, state stays IDLE.
- **WAIT, on `dmem_rvalid`:**
  - Align and extend `dmem_rdata`:
    - LB: byte `addr_lo` (bits `[8*lo+7:8*lo]`), sign-extended.
    - LBU: same byte, zero-extended.
    - LH/LHU: halfword `addr_lo[1]`, sign- or zero-extended.
    - LW: full word.
  - Next cycle `wb_we` pulses (suppressed for `$0` or `wreg`=0). Go to IDLE.
- **WAIT, `flush`:** no write. If `dmem_rvalid` is asserted in the same cycle, the response is consumed and the state goes to IDLE; otherwise go to DRAIN.
- **DRAIN:** discard the next `dmem_rvalid`, then go to IDLE. `flush` in DRAIN has no additional effect.
- `wb_pend` = (state==WAIT) && captured `wreg` && captured `waddr`!=0. `wb_pend_waddr` = captured `waddr`.
- Flush in IDLE blocks acceptance only; an already-registered `wb_we` pulse still completes.
- `stall` does not affect WAIT/DRAIN progress.
- Unknown `load_op` codes are treated as LW.

## Timing
- Reset (async, `rst`=0): state IDLE; `wb_we`, `wb_waddr`, `wb_wdata`, `wb_misalign`, all captured fields = 0; `wb_pend`=0. `wb_ready`=1 after release, when `stall` and `flush` are both 0.
- ALU path latency: accept at edge N, write pulse visible during cycle N+1 (one cycle wide).
- Load path latency: `dmem_rvalid` sampled at edge M, write pulse during cycle M+1. Minimum accept-to-write is 2 cycles.
- Back-to-back ALU instructions sustain one write per cycle.
- A load blocks acceptance from the accept edge until the response edge inclusive.
- Reset asserted mid-WAIT or mid-DRAIN returns to IDLE immediately. Any later `dmem_rvalid` is ignored in IDLE.
- All outputs except `wb_ready`, `wb_pend` and `wb_pend_waddr` are registered.

## Structure
- `define.v` gains: `LoadOpBus` (3 bits); codes `LB`=0, `LBU`=1, `LH`=2, `LHU`=3, `LW`=4; the `WbState` encodings.
- Existing `RegBus`, `RegAddrBus`, `ZeroWord`, `RstEnable` (retargeted to 1'b0), `WriteEnable` are reused.
- Sub-module `load_align` holds the purely combinational byte/half selection and extension: (`load_op`, `addr_lo`, `rdata`) -> `aligned`.

## Test plan
- ALU: accept `waddr`=3, `wdata`=0xDEADBEEF -> next cycle `wb_we`=1, `waddr`=3, `wdata`=0xDEADBEEF; one cycle later `wb_we`=0.
- `$0` suppression: accept `mem_wreg`=1, `waddr`=0 -> `wb_we` stays 0.
- LB, `addr_lo`=2, `rdata`=0x1280_7F34 -> `wdata`=0xFFFFFF80. LBU -> 0x00000080. LHU, `addr_lo`=2 -> 0x00001280. LW -> 0x12807F34. `wb_pend`=1 with `pend_waddr` while waiting; `wb_ready`=0 throughout.
- Misaligned LW, `addr_lo`=1 -> `wb_misalign` pulses, `wb_we`=0, `wb_ready` back to 1 next cycle.
- Load, then `flush` 2 cycles later, `rvalid` 3 cycles later -> no write, DRAIN consumes the response, then IDLE. Also cover flush and `rvalid` in the same cycle -> straight to IDLE.
- `rst` pulsed low mid-WAIT -> all outputs 0 asynchronously; a subsequent `rvalid` produces no write.
